// File: rtl/led_mode_ctrl_if.sv
// led_mode_ctrl_if: key/LED bundle between the key filter, the LED mode
// controller and whatever drives or observes it.
//   key_pulse  one-cycle debounced press pulse    (master -> slave)
//   en         1 = animate, 0 = freeze            (master -> slave)
//   led        registered LED drive, 1 = lit      (slave -> master)
//   mode       current mode code                  (slave -> master)
//   tick       registered one-cycle step strobe   (slave -> master)
interface led_mode_ctrl_if #(
    parameter int LED_W = 8
);
    logic             key_pulse;
    logic             en;
    logic [LED_W-1:0] led;
    logic [2:0]       mode;
    logic             tick;

    modport master (output key_pulse, en, input led, mode, tick);
    modport slave  (input key_pulse, en, output led, mode, tick);
endinterface

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: key-pulse driven LED mode selector with a prescaled
// pattern animator.
//   clk   system clock
//   rst   asynchronous reset, active-high
//   bus   led_mode_ctrl_if.slave (key_pulse, en in; led, mode, tick out)
// Modes: 0 OFF, 1 ON, 2 BLINK, 3 SHL, 4 SHR, 5 PINGPONG, 6 BREATH.
// Optional feature macro LED_BREATH_EN adds mode 6 (PWM breathing);
// without it the mode wraps 5 -> 0.
module led_mode_ctrl #(
    parameter int LED_W    = 8,
    parameter int TICK_DIV = 25_000_000,
    parameter int TICK_W   = 25
) (
    input  logic           clk,
    input  logic           rst,
    led_mode_ctrl_if.slave bus
);
    localparam logic [2:0] M_OFF    = 3'd0;
    localparam logic [2:0] M_ON     = 3'd1;
    localparam logic [2:0] M_BLINK  = 3'd2;
    localparam logic [2:0] M_SHL    = 3'd3;
    localparam logic [2:0] M_SHR    = 3'd4;
    localparam logic [2:0] M_PP     = 3'd5;
`ifdef LED_BREATH_EN
    localparam logic [2:0] M_BREATH = 3'd6;
    localparam logic [2:0] M_LAST   = M_BREATH;
`else
    localparam logic [2:0] M_LAST   = M_PP;
`endif

    localparam logic [TICK_W-1:0] CNT_MAX = TICK_W'(TICK_DIV - 1);

    logic [2:0]        mode_q, mode_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic              tick_q, tick_d;
    logic [TICK_W-1:0] cnt_q, cnt_d;
    logic              dir_q, dir_d;     // pingpong: 0 = moving left (up)
    logic              step;

`ifdef LED_BREATH_EN
    logic [7:0] pwm_q, pwm_d;
    logic [7:0] duty_q, duty_d;
    logic       ramp_dn_q, ramp_dn_d;
`endif

    assign step = bus.en && (cnt_q == CNT_MAX);

    // Pattern loaded when a mode is entered.
    function automatic logic [LED_W-1:0] init_led(input logic [2:0] m);
        logic [LED_W-1:0] v;
        v = '0;
        case (m)
            M_ON, M_BLINK: v = '1;
            M_SHL, M_PP:   v[0] = 1'b1;
            M_SHR:         v[LED_W-1] = 1'b1;
            default:       v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        mode_d = mode_q;
        led_d  = led_q;
        tick_d = 1'b0;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
`ifdef LED_BREATH_EN
        duty_d    = duty_q;
        ramp_dn_d = ramp_dn_q;
        pwm_d     = (mode_q == M_BREATH) ? pwm_q + 8'd1 : 8'd0;
`endif
        if (bus.key_pulse) begin
            // Key press has priority over a coincident step: reload only.
            // Out-of-range codes fall into the >= compare and return to OFF.
            mode_d = (mode_q >= M_LAST) ? M_OFF : mode_q + 3'd1;
            cnt_d  = '0;
            dir_d  = 1'b0;
            led_d  = init_led(mode_d);
`ifdef LED_BREATH_EN
            duty_d    = 8'd0;
            ramp_dn_d = 1'b0;
`endif
        end else if (bus.en) begin
            cnt_d  = step ? '0 : cnt_q + 1'b1;
            tick_d = step;
`ifdef LED_BREATH_EN
            if (mode_q == M_BREATH)
                led_d = {LED_W{pwm_q < duty_q}};
`endif
            if (step) begin
                case (mode_q)
                    M_BLINK: led_d = ~led_q;
                    M_SHL:   led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                    M_SHR:   led_d = {led_q[0], led_q[LED_W-1:1]};
                    M_PP: begin
                        // Flip direction as the lit bit arrives at an end.
                        if (!dir_q) begin
                            led_d = led_q << 1;
                            if (led_q[LED_W-2]) dir_d = 1'b1;
                        end else begin
                            led_d = led_q >> 1;
                            if (led_q[1]) dir_d = 1'b0;
                        end
                    end
`ifdef LED_BREATH_EN
                    M_BREATH: begin
                        if (!ramp_dn_q) begin
                            duty_d = duty_q + 8'd1;
                            if (duty_q == 8'd254) ramp_dn_d = 1'b1;
                        end else begin
                            duty_d = duty_q - 8'd1;
                            if (duty_q == 8'd1) ramp_dn_d = 1'b0;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= M_OFF;
            led_q  <= '0;
            tick_q <= 1'b0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
`ifdef LED_BREATH_EN
            pwm_q     <= 8'd0;
            duty_q    <= 8'd0;
            ramp_dn_q <= 1'b0;
`endif
        end else begin
            mode_q <= mode_d;
            led_q  <= led_d;
            tick_q <= tick_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
`ifdef LED_BREATH_EN
            pwm_q     <= pwm_d;
            duty_q    <= duty_d;
            ramp_dn_q <= ramp_dn_d;
`endif
        end
    end

    assign bus.led  = led_q;
    assign bus.mode = mode_q;
    assign bus.tick = tick_q;
endmodule

// File: tb/tb_led_mode_ctrl.sv
module tb_led_mode_ctrl;
    typedef struct {
        string      tag;
        logic [3:0] led;
        logic [2:0] mode;
        logic       tick;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [3:0] pp [0:8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4};

    led_mode_ctrl_if #(.LED_W(4)) bus ();

    led_mode_ctrl #(.LED_W(4), .TICK_DIV(4), .TICK_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic compare(input exp_t x);
        checks++;
        assert ({bus.led, bus.mode, bus.tick} === {x.led, x.mode, x.tick})
        else begin
            errors++;
            $error("FAIL %s led/mode/tick got=%h/%0d/%0d exp=%h/%0d/%0d",
                   x.tag, bus.led, bus.mode, bus.tick, x.led, x.mode, x.tick);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs,
    // then pop and compare once the edge has produced them.
    task automatic cyc(input logic kp, input logic e, input logic [3:0] xl,
                       input logic [2:0] xm, input logic xt, input string tag);
        exp_t x;
        bus.key_pulse = kp;
        bus.en        = e;
        x.tag = tag; x.led = xl; x.mode = xm; x.tick = xt;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        compare(x);
    endtask

    task automatic chk_now(input logic [3:0] xl, input logic [2:0] xm,
                           input logic xt, input string tag);
        exp_t x;
        x.tag = tag; x.led = xl; x.mode = xm; x.tick = xt;
        compare(x);
    endtask

    // Press from the last animated mode back to OFF.
    task automatic wrap_from5(input logic e);
`ifdef LED_BREATH_EN
        cyc(1'b1, e, 4'h0, 3'd6, 1'b0, "to_breath");
`endif
        cyc(1'b1, e, 4'h0, 3'd0, 1'b0, "wrap_off");
    endtask

    initial begin
        rst = 1'b1;
        bus.key_pulse = 1'b0;
        bus.en = 1'b0;
        #12;
        chk_now(4'h0, 3'd0, 1'b0, "reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Walk every mode with en=0: initial patterns.
        cyc(1'b1, 1'b0, 4'hF, 3'd1, 1'b0, "p_on");
        cyc(1'b1, 1'b0, 4'hF, 3'd2, 1'b0, "p_blink");
        cyc(1'b1, 1'b0, 4'h1, 3'd3, 1'b0, "p_shl");
        cyc(1'b1, 1'b0, 4'h8, 3'd4, 1'b0, "p_shr");
        cyc(1'b1, 1'b0, 4'h1, 3'd5, 1'b0, "p_pp");
        wrap_from5(1'b0);

        // SHL animation.
        cyc(1'b1, 1'b0, 4'hF, 3'd1, 1'b0, "p_on");
        cyc(1'b1, 1'b0, 4'hF, 3'd2, 1'b0, "p_blink");
        cyc(1'b1, 1'b0, 4'h1, 3'd3, 1'b0, "p_shl");
        for (int i = 1; i <= 16; i++)
            cyc(1'b0, 1'b1, 4'(1 << ((i / 4) % 4)), 3'd3, (i % 4) == 0, "shl_run");

        // SHR animation (press while en=1).
        cyc(1'b1, 1'b1, 4'h8, 3'd4, 1'b0, "p_shr");
        for (int i = 1; i <= 16; i++)
            cyc(1'b0, 1'b1, 4'(8 >> ((i / 4) % 4)), 3'd4, (i % 4) == 0, "shr_run");

        // PINGPONG for 8 ticks.
        cyc(1'b1, 1'b1, 4'h1, 3'd5, 1'b0, "p_pp");
        for (int i = 1; i <= 32; i++)
            cyc(1'b0, 1'b1, pp[i / 4], 3'd5, (i % 4) == 0, "pp_run");

        // BLINK for 3 ticks.
        wrap_from5(1'b0);
        cyc(1'b1, 1'b0, 4'hF, 3'd1, 1'b0, "p_on");
        cyc(1'b1, 1'b0, 4'hF, 3'd2, 1'b0, "p_blink");
        for (int i = 1; i <= 12; i++)
            cyc(1'b0, 1'b1, ((i / 4) % 2) ? 4'h0 : 4'hF, 3'd2, (i % 4) == 0, "blink_run");

        // Key press on the exact step edge in SHL at led=4.
        cyc(1'b1, 1'b1, 4'h1, 3'd3, 1'b0, "p_shl");
        for (int i = 1; i <= 11; i++)
            cyc(1'b0, 1'b1, 4'(1 << (i / 4)), 3'd3, (i % 4) == 0, "shl_pre");
        cyc(1'b1, 1'b1, 4'h8, 3'd4, 1'b0, "kp_on_tick");
        for (int i = 1; i <= 4; i++)
            cyc(1'b0, 1'b1, 4'(8 >> (i / 4)), 3'd4, i == 4, "cnt_cleared");

        // Freeze at count 2.
        cyc(1'b0, 1'b1, 4'h4, 3'd4, 1'b0, "to_cnt1");
        cyc(1'b0, 1'b1, 4'h4, 3'd4, 1'b0, "to_cnt2");
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 1'b0, 4'h4, 3'd4, 1'b0, "frozen");
        cyc(1'b0, 1'b1, 4'h4, 3'd4, 1'b0, "resume1");
        cyc(1'b0, 1'b1, 4'h2, 3'd4, 1'b1, "resume_tick");

        // Asynchronous reset mid-SHL.
        cyc(1'b1, 1'b0, 4'h1, 3'd5, 1'b0, "p_pp");
        wrap_from5(1'b0);
        cyc(1'b1, 1'b0, 4'hF, 3'd1, 1'b0, "p_on");
        cyc(1'b1, 1'b0, 4'hF, 3'd2, 1'b0, "p_blink");
        cyc(1'b1, 1'b0, 4'h1, 3'd3, 1'b0, "p_shl");
        for (int i = 1; i <= 5; i++)
            cyc(1'b0, 1'b1, 4'(1 << (i / 4)), 3'd3, (i % 4) == 0, "shl_b4rst");
        bus.key_pulse = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_now(4'h0, 3'd0, 1'b0, "async_rst");
        rst = 1'b0;
        for (int i = 1; i <= 8; i++)
            cyc(1'b0, 1'b1, 4'h0, 3'd0, (i % 4) == 0, "off_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
